lmc_loader: RTL and testbench

LMC_LOADER -- requirements
Module: lmc_loader

---
 rtl/lmc_loader.sv | 206 ++++++++++++++++++++
 tb/tb_lmc_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lmc_loader.sv
// ----------------------------------------------------------------------------
// lmc_loader
//
// Holds a small program in an internal buffer and feeds it, word by word, to
// a Little Man Computer core that loads one instruction per RAM1_button pulse.
// Each word goes through SETUP (data stable), PULSE (strobe high), HOLD
// (strobe low, data still stable) and GAP (data cleared, core executes).
//
// Ports:
//   timer555     in   system clock, rising edge
//   reset_count  in   asynchronous active-high reset
//   prog_we      in   buffer write strobe (ignored while busy)
//   prog_addr    in   buffer write address
//   prog_wdata   in   buffer write data
//   prog_len     in   number of words to send, sampled on an accepted start
//   start        in   begin a transfer (level-sampled in IDLE)
//   abort        in   terminate a transfer in progress
//   data_in      out  instruction word presented to the core (registered)
//   RAM1_button  out  load strobe to the core (registered)
//   busy         out  transfer in progress
//   done         out  sticky completion flag
//   step_idx     out  index of the word currently presented
// ----------------------------------------------------------------------------
module lmc_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 12,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 1,
    parameter int GAP_CYC    = 2
) (
    input  logic                  timer555,
    input  logic                  reset_count,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_wdata,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  start,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  RAM1_button,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] step_idx
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // A phase length of 0 would never terminate, so it is stretched to 1.
    localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int PULSE_N = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
    localparam int GAP_N   = (GAP_CYC   < 1) ? 1 : GAP_CYC;
    localparam int MAX_SP  = (SETUP_N > PULSE_N) ? SETUP_N : PULSE_N;
    localparam int MAX_N   = (MAX_SP > GAP_N) ? MAX_SP : GAP_N;
    localparam int CNT_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0]    SETUP_LAST = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0]    PULSE_LAST = CNT_W'(PULSE_N - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(GAP_N - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        GAP,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [ADDR_WIDTH:0]     len, len_nxt;
    logic [ADDR_WIDTH-1:0]   idx_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic                    btn_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // ------------------------------------------------------------------
    // Program buffer
    // ------------------------------------------------------------------
    // NOTE: the buffer must read back as zero straight after reset, so it is
    // built from resettable flops rather than an inferred RAM macro.
    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (prog_we && !busy) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        idx_nxt   = step_idx;
        done_nxt  = done;

        case (state)
            IDLE: begin
                // abort also masks a coincident start
                if (start && !abort) begin
                    len_nxt   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                    idx_nxt   = '0;
                    done_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = (len_nxt == '0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = PULSE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                cnt_nxt   = '0;
                state_nxt = GAP;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if ({1'b0, step_idx} == len - 1'b1) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = step_idx + 1'b1;
                        state_nxt = SETUP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end

        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
        end

        // Outputs are derived from the state being entered and registered
        // below, so the core sees clean edges on data_in and RAM1_button.
        btn_nxt  = (state_nxt == PULSE);
        busy_nxt = (state_nxt == SETUP) || (state_nxt == PULSE) ||
                   (state_nxt == HOLD)  || (state_nxt == GAP);
        data_nxt = ((state_nxt == SETUP) || (state_nxt == PULSE) ||
                    (state_nxt == HOLD)) ? mem[idx_nxt] : '0;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            step_idx    <= '0;
            data_in     <= '0;
            RAM1_button <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            len         <= len_nxt;
            step_idx    <= idx_nxt;
            data_in     <= data_nxt;
            RAM1_button <= btn_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_lmc_loader.sv
// ----------------------------------------------------------------------------
// tb_lmc_loader
//
// Directed bench for lmc_loader with default parameters. Expected load pulses
// ({data_in, step_idx}) are queued as each transfer is launched; a monitor
// pops one entry per RAM1_button pulse and compares. Cycle-exact timing,
// reset behaviour and abort are checked directly from the main sequence.
// ----------------------------------------------------------------------------
module tb_lmc_loader;

    logic        timer555;
    logic        reset_count;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_wdata;
    logic [4:0]  prog_len;
    logic        start;
    logic        abort;
    logic [11:0] data_in;
    logic        RAM1_button;
    logic        busy;
    logic        done;
    logic [3:0]  step_idx;

    typedef struct packed {
        logic [11:0] data;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;

    lmc_loader dut (
        .timer555    (timer555),
        .reset_count (reset_count),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .RAM1_button (RAM1_button),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx)
    );

    initial timer555 = 1'b0;
    always #5 timer555 = ~timer555;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per load pulse, sampled on the falling edge.
    always @(negedge timer555) begin
        if (RAM1_button === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: data_in=0x%0h step_idx=%0d", data_in, step_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_data", 32'(data_in), 32'(e.data));
                check("pulse_idx", 32'(step_idx), 32'(e.idx));
            end
        end
    end

    task automatic tick();
        @(posedge timer555);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [11:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        tick();
        prog_we    = 1'b0;
    endtask

    // Returns positioned in cycle 1 (just after the edge that accepted start).
    task automatic do_start(input logic [4:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic push(input logic [11:0] d, input logic [3:0] i);
        exp_t e;
        e.data = d;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        tick();  // DONE -> IDLE
    endtask

    // Per-cycle expectations for the two-word transfer: {data_in, btn, busy, done}
    logic [14:0] tbl [11] = '{
        {12'h400, 1'b0, 1'b1, 1'b0},
        {12'h400, 1'b1, 1'b1, 1'b0},
        {12'h400, 1'b0, 1'b1, 1'b0},
        {12'h000, 1'b0, 1'b1, 1'b0},
        {12'h000, 1'b0, 1'b1, 1'b0},
        {12'h800, 1'b0, 1'b1, 1'b0},
        {12'h800, 1'b1, 1'b1, 1'b0},
        {12'h800, 1'b0, 1'b1, 1'b0},
        {12'h000, 1'b0, 1'b1, 1'b0},
        {12'h000, 1'b0, 1'b1, 1'b0},
        {12'h000, 1'b0, 1'b0, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p0;

        reset_count = 1'b1;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_wdata  = '0;
        prog_len    = '0;
        start       = 1'b0;
        abort       = 1'b0;
        #12;
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_button", 32'(RAM1_button), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_step_idx", 32'(step_idx), 32'd0);
        reset_count = 1'b0;
        tick();

        // ---- two-word transfer, cycle exact ----
        write_word(4'd0, 12'h400);
        write_word(4'd1, 12'h800);
        push(12'h400, 4'd0);
        push(12'h800, 4'd1);
        do_start(5'd2);
        for (int c = 0; c < 11; c++) begin
            check($sformatf("two_word_c%0d_data", c + 1), 32'(data_in), 32'(tbl[c][14:3]));
            check($sformatf("two_word_c%0d_btn", c + 1), 32'(RAM1_button), 32'(tbl[c][2]));
            check($sformatf("two_word_c%0d_busy", c + 1), 32'(busy), 32'(tbl[c][1]));
            check($sformatf("two_word_c%0d_done", c + 1), 32'(done), 32'(tbl[c][0]));
            if (c < 10) tick();
        end
        check("two_word_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // ---- prog_len beyond depth: clamped to 16 words ----
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 12'h100 + 12'(i));
            push(12'h100 + 12'(i), 4'(i));
        end
        p0 = pulses;
        do_start(5'd20);
        wait_done("len20_done", 200);
        check("len20_pulse_count", 32'(pulses - p0), 32'd16);

        // ---- abort during the pulse of word 1 ----
        push(12'h100, 4'd0);
        push(12'h101, 4'd1);
        do_start(5'd4);
        n = 0;
        while (!(RAM1_button === 1'b1 && step_idx == 4'd1) && n < 50) begin
            tick();
            n++;
        end
        check("abort_found_pulse", 32'(RAM1_button), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_button", 32'(RAM1_button), 32'd0);
        check("abort_data_in", 32'(data_in), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        p0 = pulses;
        for (int i = 0; i < 30; i++) tick();
        check("abort_no_more_pulses", 32'(pulses - p0), 32'd0);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // ---- zero-length start ----
        p0 = pulses;
        do_start(5'd0);
        check("len0_busy_c1", 32'(busy), 32'd0);
        check("len0_done_c1", 32'(done), 32'd1);
        tick();
        check("len0_done_c2", 32'(done), 32'd1);
        check("len0_no_pulse", 32'(pulses - p0), 32'd0);

        // ---- write while busy is ignored ----
        for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 4'(i));
        do_start(5'd4);
        tick();
        write_word(4'd3, 12'hFFF);
        wait_done("busy_write_done", 60);

        // ---- write while idle takes effect ----
        write_word(4'd3, 12'hFFF);
        push(12'h100, 4'd0);
        push(12'h101, 4'd1);
        push(12'h102, 4'd2);
        push(12'hFFF, 4'd3);
        do_start(5'd4);
        wait_done("idle_write_done", 60);

        // ---- asynchronous reset in the middle of a pulse ----
        do_start(5'd1);
        n = 0;
        while (RAM1_button !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("reset_found_pulse", 32'(RAM1_button), 32'd1);
        #1 reset_count = 1'b1;
        #1;
        check("reset_async_button", 32'(RAM1_button), 32'd0);
        check("reset_async_data_in", 32'(data_in), 32'd0);
        check("reset_async_busy", 32'(busy), 32'd0);
        check("reset_async_done", 32'(done), 32'd0);
        check("reset_async_step_idx", 32'(step_idx), 32'd0);
        @(posedge timer555);
        #2 reset_count = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) push(12'h000, 4'(i));
        do_start(5'd16);
        wait_done("post_reset_readback_done", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
